// File: rtl/double_to_pcm16_conv.sv
// rtl/double_to_pcm16_conv.sv - IEEE-754 double to 16-bit PCM converter
// Iterative 1-bit/cycle right shifter with round-half-even and saturation.
module double_to_pcm16_conv #(
    parameter int FRAC_BITS = 0
) (
    input  logic        clk_operation,
    input  logic        rst,
    input  logic        enable,
    input  logic [63:0] double,
    output logic [15:0] sig16b,
    output logic        ready,
    output logic        busy,
    output logic        sat,
    output logic        invalid
);

    typedef enum logic [1:0] {
        IDLE,
        UNPACK,
        SHIFT,
        ROUND
    } state_t;

    localparam logic signed [13:0] BIAS = 14'(1075 - FRAC_BITS);

    state_t      state_q, state_d;
    logic [63:0] op_q, op_d;
    logic [52:0] m_q, m_d;
    logic [5:0]  cnt_q, cnt_d;
    logic        guard_q, guard_d;
    logic        sticky_q, sticky_d;
    logic        satcls_q, satcls_d;
    logic        nan_q, nan_d;
    logic [15:0] sig16b_q, sig16b_d;
    logic        ready_q, ready_d;
    logic        busy_q, busy_d;
    logic        sat_q, sat_d;
    logic        invalid_q, invalid_d;

    logic [10:0]        exp_f;
    logic [51:0]        frac_f;
    logic signed [13:0] k_s;
    logic signed [13:0] nk_s;
    logic               inc;
    logic               big;
    logic [16:0]        mag17;
    logic [16:0]        neg_mag17;

    assign exp_f     = op_q[62:52];
    assign frac_f    = op_q[51:0];
    assign k_s       = $signed({3'b000, exp_f}) - BIAS;
    assign nk_s      = -k_s;
    assign inc       = guard_q & (sticky_q | m_q[0]);
    // Any bit at or above 2^16 means overflow regardless of rounding.
    assign big       = |m_q[52:16];
    assign mag17     = {1'b0, m_q[15:0]} + {16'd0, inc};
    assign neg_mag17 = 17'd0 - mag17;

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        m_d       = m_q;
        cnt_d     = cnt_q;
        guard_d   = guard_q;
        sticky_d  = sticky_q;
        satcls_d  = satcls_q;
        nan_d     = nan_q;
        sig16b_d  = sig16b_q;
        ready_d   = ready_q;
        busy_d    = busy_q;
        sat_d     = sat_q;
        invalid_d = invalid_q;
        case (state_q)
            IDLE: begin
                if (enable) begin
                    op_d      = double;
                    ready_d   = 1'b0;
                    busy_d    = 1'b1;
                    sat_d     = 1'b0;
                    invalid_d = 1'b0;
                    satcls_d  = 1'b0;
                    nan_d     = 1'b0;
                    state_d   = UNPACK;
                end
            end
            UNPACK: begin
                guard_d  = 1'b0;
                sticky_d = 1'b0;
                m_d      = 53'd0;
                state_d  = ROUND;
                if (exp_f == 11'h7FF && frac_f != 52'd0) begin
                    nan_d = 1'b1;
                end else if (exp_f == 11'h7FF) begin
                    satcls_d = 1'b1;
                end else if (exp_f == 11'd0) begin
                    m_d = 53'd0;
                end else if (k_s >= 14'sd0) begin
                    satcls_d = 1'b1;
                end else if (k_s <= -14'sd54) begin
                    m_d = 53'd0;
                end else begin
                    m_d     = {1'b1, frac_f};
                    cnt_d   = nk_s[5:0];
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                sticky_d = sticky_q | guard_q;
                guard_d  = m_q[0];
                m_d      = m_q >> 1;
                cnt_d    = cnt_q - 6'd1;
                if (cnt_q == 6'd1) begin
                    state_d = ROUND;
                end
            end
            ROUND: begin
                sat_d     = 1'b0;
                invalid_d = 1'b0;
                if (nan_q) begin
                    sig16b_d  = 16'h0000;
                    invalid_d = 1'b1;
                end else if (satcls_q) begin
                    sig16b_d = op_q[63] ? 16'h8000 : 16'h7FFF;
                    sat_d    = 1'b1;
                end else if (!op_q[63]) begin
                    if (big || mag17 > 17'd32767) begin
                        sig16b_d = 16'h7FFF;
                        sat_d    = 1'b1;
                    end else begin
                        sig16b_d = mag17[15:0];
                    end
                end else begin
                    // -32768 is representable, so only magnitudes past it clip.
                    if (big || mag17 > 17'd32768) begin
                        sig16b_d = 16'h8000;
                        sat_d    = 1'b1;
                    end else begin
                        sig16b_d = neg_mag17[15:0];
                    end
                end
                ready_d = 1'b1;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_operation) begin
        if (rst) begin
            state_q   <= IDLE;
            op_q      <= 64'd0;
            m_q       <= 53'd0;
            cnt_q     <= 6'd0;
            guard_q   <= 1'b0;
            sticky_q  <= 1'b0;
            satcls_q  <= 1'b0;
            nan_q     <= 1'b0;
            sig16b_q  <= 16'd0;
            ready_q   <= 1'b0;
            busy_q    <= 1'b0;
            sat_q     <= 1'b0;
            invalid_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            m_q       <= m_d;
            cnt_q     <= cnt_d;
            guard_q   <= guard_d;
            sticky_q  <= sticky_d;
            satcls_q  <= satcls_d;
            nan_q     <= nan_d;
            sig16b_q  <= sig16b_d;
            ready_q   <= ready_d;
            busy_q    <= busy_d;
            sat_q     <= sat_d;
            invalid_q <= invalid_d;
        end
    end

    assign sig16b  = sig16b_q;
    assign ready   = ready_q;
    assign busy    = busy_q;
    assign sat     = sat_q;
    assign invalid = invalid_q;

endmodule

// File: tb/tb_double_to_pcm16_conv.sv
// tb/tb_double_to_pcm16_conv.sv - scoreboard bench for double_to_pcm16_conv
// Directed vectors with hand-computed results and latencies.
module tb_double_to_pcm16_conv;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic [63:0] dbl;
    logic [15:0] sig16b;
    logic        ready, busy, sat, invalid;

    double_to_pcm16_conv #(.FRAC_BITS(0)) dut (
        .clk_operation(clk),
        .rst          (rst),
        .enable       (enable),
        .double       (dbl),
        .sig16b       (sig16b),
        .ready        (ready),
        .busy         (busy),
        .sat          (sat),
        .invalid      (invalid)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] sig;
        logic        sat;
        logic        inv;
        int          lat;
        int          acc;
    } exp_t;

    exp_t exp_q[$];
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    int   results = 0;
    logic ready_prev = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, expv);
        end
    endtask

    always @(negedge clk) begin
        if (ready && !ready_prev) begin
            results++;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_result actual=%0h required=none", sig16b);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("sig16b", 32'(sig16b), 32'(e.sig));
                chk("sat", 32'(sat), 32'(e.sat));
                chk("invalid", 32'(invalid), 32'(e.inv));
                chk("latency", 32'(cyc - e.acc), 32'(e.lat));
                chk("busy_at_ready", 32'(busy), 32'd0);
            end
        end
        ready_prev = ready;
    end

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (busy) begin
            checks++;
            errors++;
            $display("FAIL idle_timeout actual=busy required=idle");
        end
    endtask

    task automatic issue(input logic [63:0] d, input logic [15:0] es, input logic esat,
                         input logic einv, input int elat, input bit push);
        exp_t e;
        wait_idle();
        enable = 1'b1;
        dbl    = d;
        @(posedge clk);
        #1;
        enable = 1'b0;
        e.sig = es; e.sat = esat; e.inv = einv; e.lat = elat; e.acc = cyc;
        if (push) exp_q.push_back(e);
    endtask

    initial begin
        rst    = 1'b1;
        enable = 1'b0;
        dbl    = 64'd0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_sig16b", 32'(sig16b), 32'd0);
        chk("reset_ready", 32'(ready), 32'd0);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_sat_inv", 32'({sat, invalid}), 32'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        issue(64'h3FF0000000000000, 16'h0001, 1'b0, 1'b0, 54, 1'b1);
        chk("busy_after_accept", 32'(busy), 32'd1);
        // re-pulse at N+10 with a different operand; must be ignored
        repeat (9) begin @(posedge clk); #1; end
        enable = 1'b1;
        dbl    = 64'h4008000000000000;
        @(posedge clk);
        #1;
        enable = 1'b0;
        chk("busy_during_ignored", 32'(busy), 32'd1);

        // back-to-back: each is accepted on the edge after ROUND
        issue(64'hC004000000000000, 16'hFFFE, 1'b0, 1'b0, 53, 1'b1);
        issue(64'h3FF8000000000000, 16'h0002, 1'b0, 1'b0, 54, 1'b1);
        issue(64'h3FE0000000000000, 16'h0000, 1'b0, 1'b0, 55, 1'b1);
        issue(64'h3FE8000000000000, 16'h0001, 1'b0, 1'b0, 55, 1'b1);
        issue(64'h3FD0000000000000, 16'h0000, 1'b0, 1'b0, 2, 1'b1);
        issue(64'h40E3880000000000, 16'h7FFF, 1'b1, 1'b0, 39, 1'b1);
        issue(64'hC0E0000000000000, 16'h8000, 1'b0, 1'b0, 39, 1'b1);
        issue(64'h40DFFFE000000000, 16'h7FFF, 1'b1, 1'b0, 40, 1'b1);
        issue(64'hBFF0000000000000, 16'hFFFF, 1'b0, 1'b0, 54, 1'b1);
        issue(64'h7FF0000000000000, 16'h7FFF, 1'b1, 1'b0, 2, 1'b1);
        issue(64'hFFF0000000000000, 16'h8000, 1'b1, 1'b0, 2, 1'b1);
        issue(64'h7FF8000000000000, 16'h0000, 1'b0, 1'b1, 2, 1'b1);
        issue(64'h0000000000000001, 16'h0000, 1'b0, 1'b0, 2, 1'b1);
        issue(64'h3FF0000000000000, 16'h0001, 1'b0, 1'b0, 54, 1'b1);

        // abort mid-SHIFT: reset at N+20, no result may appear
        issue(64'h4008000000000000, 16'h0003, 1'b0, 1'b0, 53, 1'b0);
        repeat (19) begin @(posedge clk); #1; end
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("abort_sig16b", 32'(sig16b), 32'd0);
        chk("abort_ready", 32'(ready), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_sat_inv", 32'({sat, invalid}), 32'd0);
        repeat (60) begin @(posedge clk); #1; end
        chk("abort_no_result", 32'(ready), 32'd0);

        issue(64'h4008000000000000, 16'h0003, 1'b0, 1'b0, 53, 1'b1);
        begin
            int n = 0;
            while (exp_q.size() != 0 && n < 200) begin
                @(posedge clk);
                #1;
                n++;
            end
        end
        repeat (3) @(posedge clk);
        #1;
        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        chk("result_count", 32'(results), 32'd16);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
